// File: rtl/strassen_am_pkg.sv
// rtl/strassen_am_pkg.sv - shared widths and state encoding for the sequential divider
package strassen_am_pkg;

    localparam int NW_DEF  = 8;
    localparam int DW_DEF  = 4;
    localparam int STEP_CW = $clog2(NW_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/approx_div_seq_div_step.sv
// rtl/approx_div_seq_div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract
module div_step #(
    parameter int DW = 4
) (
    input  logic [DW:0]   p,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   p_next,
    output logic          q_bit
);

    logic [DW+1:0] p_wide;

    // p is always below the divisor, so the shifted value fits in DW+1 bits after subtraction
    assign p_wide = {p, bit_in};
    assign q_bit  = (p_wide >= {2'b00, divisor});
    assign p_next = q_bit ? (DW+1)'(p_wide - {2'b00, divisor}) : (DW+1)'(p_wide);

endmodule

// File: rtl/approx_div_seq.sv
// rtl/approx_div_seq.sv - sequential restoring divider, one quotient bit per cycle, valid/ready handshakes
module approx_div_seq
    import strassen_am_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(NW + 1);

    state_t        state;
    logic [NW-1:0] d_reg;
    logic [DW-1:0] dvs_reg;
    logic [DW:0]   p_reg;
    logic [CW-1:0] count;
    logic [DW:0]   p_next;
    logic          q_bit;

    div_step #(.DW(DW)) u_step (
        .p       (p_reg),
        .bit_in  (d_reg[NW-1]),
        .divisor (dvs_reg),
        .p_next  (p_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            d_reg       <= '0;
            dvs_reg     <= '0;
            p_reg       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg    <= dividend;
                        dvs_reg  <= divisor;
                        p_reg    <= '0;
                        count    <= CW'(NW);
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quotient    <= '0;
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    p_reg    <= p_next;
                    quotient <= {quotient[NW-2:0], q_bit};
                    d_reg    <= {d_reg[NW-2:0], 1'b0};
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        remainder <= p_next[DW-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // result registers hold until the consumer takes them
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_div_seq.sv
// tb/tb_approx_div_seq.sv - directed and exhaustive-sweep bench for approx_div_seq
module tb_approx_div_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad = 0;

    approx_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [3:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b + 4'd5;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] q, input logic [3:0] r, input logic dbz,
                           input int lat_exp);
        int lat;
        accept(a, b);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_q"}, 32'(quotient), 32'(q));
        check({tag, "_r"}, 32'(remainder), 32'(r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(dbz));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_res;
        int lat;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 32'({in_ready, out_valid, quotient, remainder, div_by_zero}),
              32'({1'b1, 1'b0, 8'd0, 4'd0, 1'b0}));

        // normal divides complete 8 edges after accept; divide-by-zero is valid right after the accept edge
        run_one("45_5", 8'd45, 4'd5, 8'd9, 4'd0, 1'b0, 8);
        run_one("255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
        run_one("200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
        run_one("0_3", 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 8);
        run_one("7_9", 8'd7, 4'd9, 8'd0, 4'd7, 1'b0, 8);
        run_one("255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
        run_one("100_0", 8'd100, 4'd0, 8'hFF, 4'd4, 1'b1, 0);
        run_one("45_5_after_dbz", 8'd45, 4'd5, 8'd9, 4'd0, 1'b0, 8);

        // backpressure with ignored input pulses
        accept(8'd200, 4'd7);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 8'd99;
            divisor  = 4'd3;
            check("bp_hold", 32'({out_valid, in_ready, quotient, remainder}),
                  32'({1'b1, 1'b0, 8'd28, 4'd4}));
            tick();
        end
        in_valid = 1'b0;
        check("bp_hold_last", 32'({out_valid, quotient, remainder}), 32'({1'b1, 8'd28, 4'd4}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_one("99_3", 8'd99, 4'd3, 8'd33, 4'd0, 1'b0, 8);

        // reset at BUSY step 4
        accept(8'd200, 4'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid", 32'({in_ready, out_valid, quotient, remainder, div_by_zero}),
              32'({1'b1, 1'b0, 8'd0, 4'd0, 1'b0}));
        run_one("45_5_post_rst", 8'd45, 4'd5, 8'd9, 4'd0, 1'b0, 8);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 1)) tick();
                accept(8'(a), 4'(b));
                wait_done(lat);
                if (b == 0) exp_res = {1'b1, 8'hFF};
                else        exp_res = {1'b0, 8'(a / b)};
                check($sformatf("sweep_%0d_%0d", a, b),
                      32'({out_valid, div_by_zero, quotient, remainder}),
                      32'({1'b1, exp_res, (b == 0) ? 4'(a) : 4'(a % b)}));
                repeat ($urandom_range(0, 1)) tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                check($sformatf("sweep_one_%0d_%0d", a, b), 32'(out_valid), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
